lv8_encode_loader: RTL
======================

Name: lv8_encode_loader

Overview:
- Inverse of the CPU instruction decoder: accepts symbolic LEGv8 operations (op + register fields + signed immediate) over a valid/ready handshake, encodes them into 32-bit instruction words, and streams them to instruction memory at auto-incrementing word addresses.
- Used by the on-board program loader and the song/test-program builder to fill instruction memory before the CPU is released from reset.
- Covers exactly the CPU's supported set: ADDI, B, LDUR, STUR, ADDS, SUBS, CBZ, B.cond, BL, BR.

Parameters:
DEPTH, 1024, instruction memory size in words; the loader is full after DEPTH writes.
ADDR_W, $clog2(DEPTH), width of the word address.

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
start  in  1  one-cycle pulse: begin a new load at address 0
op_valid  in  1  operation request valid
op_ready  out  1  operation accepted this cycle when op_valid&op_ready
op_code  in  4  lv8_op_e: 0 ADDI, 1 B, 2 LDUR, 3 STUR, 4 ADDS, 5 SUBS, 6 CBZ, 7 BCOND, 8 BL, 9 BR; 10-15 illegal
rd  in  5  Rd/Rt; condition code for BCOND; target register for BR
rn  in  5  Rn
rm  in  5  Rm (ADDS/SUBS only)
imm  in  32  signed two's-complement immediate/offset (word units for branches)
wr_valid  out  1  memory write word valid
wr_ready  in  1  memory accepts the word
wr_addr  out  ADDR_W  word address
wr_data  out  32  encoded instruction
busy  out  1  high in LOAD state
full  out  1  high in FULL state
words  out  ADDR_W+1  words written since start
err  out  1  sticky: an op was rejected since start
err_cnt  out  8  rejected-op count, saturates at 255

Behaviour:
- Reset: state IDLE; op_ready, wr_valid, busy, full, err = 0; wr_addr, wr_data, words, err_cnt = 0.
- States: IDLE (op_ready=0), LOAD, FULL (op_ready=0). start from any state -> LOAD; clears wr_addr, words, err, err_cnt; discards any pending word (wr_valid=0 next cycle). start has priority over a same-cycle handshake.
- LOAD: op_ready = !wr_valid | wr_ready (single-entry output register, back-to-back at 1 op/cycle with wr_ready high).
- Latency: op accepted at edge N -> wr_valid=1 with wr_data/wr_addr valid after edge N. Held stable until wr_valid&wr_ready.
- On each completed write: wr_addr+1, words+1. Write of address DEPTH-1 -> FULL; wr_addr wraps to 0 but no further writes until start.
- Encodings (bits 31:0, all unused fields 0):
  ADDI: 1001000100 | imm[11:0] | rn | rd; legal 0<=imm<=4095.
  B / BL: 000101 / 100101 | imm[25:0]; legal -2^25..2^25-1.
  LDUR / STUR: 11111000010 / 11111000000 | imm[8:0] | 00 | rn | rd; legal -256..255.
  ADDS / SUBS: 10101011000 / 11101011000 | rm | 000000 | rn | rd.
  CBZ: 10110100 | imm[18:0] | rd; BCOND: 01010100 | imm[18:0] | rd; legal -2^18..2^18-1; BCOND also needs rd<=15.
  BR: 11010110000 | 0 (bits 20:5) | rd.
- Reject (illegal op_code or immediate/cond out of range): op is still handshaken (op_ready unaffected), no word produced, err=1, err_cnt+1 saturating. Address and words unchanged.
- Reset mid-load returns to IDLE; partially written memory is not cleared.

Decomposition:
- Package lv8_pkg: lv8_op_e enum; 11-bit/10-bit/8-bit/6-bit opcode constants shared with the decoder; immediate width constants (12, 9, 19, 26).
- Sub-module lv8_encode: purely combinational op+fields -> {word, legal}; the top holds FSM, output register, and counters.

Test Plan:
- ADDI rd=1 rn=2 imm=5 after start, wr_ready=1 -> wr_data=0x91001441, wr_addr=0, next cycle words=1.
- Back-to-back B imm=-1, LDUR rd=3 rn=4 imm=-8, SUBS rd=5 rn=6 rm=7, CBZ rd=9 imm=3, BR rd=30 -> 0x17FFFFFF, 0xF85F8083, 0xEB0700C5, 0xB4000069, 0xD600001E at addresses 0..4, one per cycle.
- wr_ready=0 for 3 cycles with word pending -> wr_data/wr_addr stable, op_ready=0, single write when wr_ready rises.
- ADDI imm=4096, then op_code=12 -> no writes, err=1, err_cnt=2, wr_addr unchanged; next legal op written at same address.
- DEPTH=4: 4 legal ops -> full=1 after 4th write, op_ready=0; start -> LOAD, wr_addr=0, words=0, full=0.
- start asserted while word pending and wr_ready=0 -> wr_valid=0 next cycle, no write of discarded word.

Source files
------------

// File: rtl/lv8_pkg.sv
// LEGv8 operation codes, opcode field constants and immediate widths shared
// by the instruction encoder and the CPU decoder.
package lv8_pkg;

  typedef enum logic [3:0] {
    OP_ADDI  = 4'd0,
    OP_B     = 4'd1,
    OP_LDUR  = 4'd2,
    OP_STUR  = 4'd3,
    OP_ADDS  = 4'd4,
    OP_SUBS  = 4'd5,
    OP_CBZ   = 4'd6,
    OP_BCOND = 4'd7,
    OP_BL    = 4'd8,
    OP_BR    = 4'd9
  } lv8_op_e;

  localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
  localparam logic [10:0] OPC_STUR  = 11'b11111000000;
  localparam logic [10:0] OPC_ADDS  = 11'b10101011000;
  localparam logic [10:0] OPC_SUBS  = 11'b11101011000;
  localparam logic [10:0] OPC_BR    = 11'b11010110000;
  localparam logic [9:0]  OPC_ADDI  = 10'b1001000100;
  localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
  localparam logic [7:0]  OPC_BCOND = 8'b01010100;
  localparam logic [5:0]  OPC_B     = 6'b000101;
  localparam logic [5:0]  OPC_BL    = 6'b100101;

  localparam int unsigned IMM_ADDI_W = 12;
  localparam int unsigned IMM_DT_W   = 9;
  localparam int unsigned IMM_CB_W   = 19;
  localparam int unsigned IMM_BR_W   = 26;

  // True when v is representable as a w-bit two's-complement value.
  function automatic logic fits_signed(input logic signed [31:0] v, input int unsigned w);
    logic signed [31:0] lim;
    lim = 32'sd1 <<< (w - 1);
    return (v >= -lim) && (v < lim);
  endfunction

endpackage

// File: rtl/lv8_encode_loader_if.sv
// Operation request channel plus instruction-memory write channel of the loader.
interface lv8_encode_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              op_valid;
  logic              op_ready;
  logic [3:0]        op_code;
  logic [4:0]        rd;
  logic [4:0]        rn;
  logic [4:0]        rm;
  logic [31:0]       imm;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output op_valid, op_code, rd, rn, rm, imm, wr_ready,
    input  op_ready, wr_valid, wr_addr, wr_data
  );

  modport slave (
    input  op_valid, op_code, rd, rn, rm, imm, wr_ready,
    output op_ready, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/lv8_encode.sv
// Combinational LEGv8 encoder: symbolic op and fields to a 32-bit word,
// with a legality flag covering op code, immediate range and condition code.
module lv8_encode
  import lv8_pkg::*;
(
  input  logic [3:0]  op_code,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  logic signed [31:0] simm;
  assign simm = signed'(imm);

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (op_code)
      OP_ADDI: begin
        word  = {OPC_ADDI, imm[IMM_ADDI_W-1:0], rn, rd};
        legal = (imm[31:IMM_ADDI_W] == '0);
      end
      OP_B: begin
        word  = {OPC_B, imm[IMM_BR_W-1:0]};
        legal = fits_signed(simm, IMM_BR_W);
      end
      OP_BL: begin
        word  = {OPC_BL, imm[IMM_BR_W-1:0]};
        legal = fits_signed(simm, IMM_BR_W);
      end
      OP_LDUR: begin
        word  = {OPC_LDUR, imm[IMM_DT_W-1:0], 2'b00, rn, rd};
        legal = fits_signed(simm, IMM_DT_W);
      end
      OP_STUR: begin
        word  = {OPC_STUR, imm[IMM_DT_W-1:0], 2'b00, rn, rd};
        legal = fits_signed(simm, IMM_DT_W);
      end
      OP_ADDS: begin
        word  = {OPC_ADDS, rm, 6'b000000, rn, rd};
        legal = 1'b1;
      end
      OP_SUBS: begin
        word  = {OPC_SUBS, rm, 6'b000000, rn, rd};
        legal = 1'b1;
      end
      OP_CBZ: begin
        word  = {OPC_CBZ, imm[IMM_CB_W-1:0], rd};
        legal = fits_signed(simm, IMM_CB_W);
      end
      OP_BCOND: begin
        // rd carries the 4-bit condition code here
        word  = {OPC_BCOND, imm[IMM_CB_W-1:0], rd};
        legal = fits_signed(simm, IMM_CB_W) && !rd[4];
      end
      OP_BR: begin
        word  = {OPC_BR, 16'h0000, rd};
        legal = 1'b1;
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/lv8_encode_loader.sv
// Program loader: encodes accepted LEGv8 ops and streams them into
// instruction memory at consecutive word addresses from 0 after start.
module lv8_encode_loader
  import lv8_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  lv8_encode_loader_if.slave   bus,
  output logic                 busy,
  output logic                 full,
  output logic [ADDR_W:0]      words,
  output logic                 err,
  output logic [7:0]           err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL} state_e;

  state_e      state;
  logic [31:0] enc_word;
  logic        enc_legal;
  logic        last_slot;
  logic        wr_fire;
  logic        op_fire;

  lv8_encode u_encode (
    .op_code (bus.op_code),
    .rd      (bus.rd),
    .rn      (bus.rn),
    .rm      (bus.rm),
    .imm     (bus.imm),
    .word    (enc_word),
    .legal   (enc_legal)
  );

  assign last_slot = (bus.wr_addr == ADDR_W'(DEPTH - 1));
  // While the last slot is pending no new op is taken, so none is dropped on entering FULL.
  assign bus.op_ready = (state == S_LOAD) && (!bus.wr_valid || (bus.wr_ready && !last_slot));
  assign wr_fire      = bus.wr_valid && bus.wr_ready;
  assign op_fire      = bus.op_valid && bus.op_ready;
  assign busy         = (state == S_LOAD);
  assign full         = (state == S_FULL);

  // FSM, single-entry output register and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      bus.wr_valid <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      words        <= '0;
      err          <= 1'b0;
      err_cnt      <= '0;
    end else if (start) begin
      state        <= S_LOAD;
      bus.wr_valid <= 1'b0;
      bus.wr_addr  <= '0;
      words        <= '0;
      err          <= 1'b0;
      err_cnt      <= '0;
    end else begin
      if (wr_fire) begin
        bus.wr_valid <= 1'b0;
        words        <= words + (ADDR_W+1)'(1);
        if (last_slot) begin
          bus.wr_addr <= '0;
          state       <= S_FULL;
        end else begin
          bus.wr_addr <= bus.wr_addr + ADDR_W'(1);
        end
      end
      if (op_fire) begin
        if (enc_legal) begin
          bus.wr_valid <= 1'b1;
          bus.wr_data  <= enc_word;
        end else begin
          err <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

endmodule
